// File: rtl/psi_pkg.sv
// Shared PSI definitions: FSM state encoding and reset-time divider constants.
// The frequency regulator starts from the same reset divider as the generator.
package psi_pkg;

  localparam int unsigned PSI_WIDTH = 8;

  localparam logic [PSI_WIDTH-1:0] PSI_RST_DIV  = 8'h7F;
  localparam logic [PSI_WIDTH-1:0] PSI_RST_HIGH = 8'h40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } psi_gen_state_t;

endpackage

// File: rtl/psi_shadow_reg.sv
// Double-buffered load path for the PSI generator.
// Ports:
//   clk, rst        clock, async active-low reset
//   load            one-cycle strobe capturing div_in/high_in
//   xfer            this edge is a transfer edge (run start or continuing boundary)
//   div_in, high_in requested settings
//   cur_div, cur_high  currently active settings
//   eff_div_c, eff_high_c  settings the next period must use (combinational)
//   load_ack        one-cycle pulse the cycle after new settings became active
module psi_shadow_reg
  import psi_pkg::*;
#(
  parameter int unsigned WIDTH = PSI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             xfer,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic [WIDTH-1:0] cur_div,
  input  logic [WIDTH-1:0] cur_high,
  output logic [WIDTH-1:0] eff_div_c,
  output logic [WIDTH-1:0] eff_high_c,
  output logic             load_ack
);

  logic [WIDTH-1:0] sh_div;
  logic [WIDTH-1:0] sh_high;
  logic             sh_valid;

  // A load on the transfer edge bypasses the shadow; it is newer than any pending value.
  always_comb begin
    eff_div_c  = cur_div;
    eff_high_c = cur_high;
    if (xfer) begin
      if (load) begin
        eff_div_c  = div_in;
        eff_high_c = high_in;
      end else if (sh_valid) begin
        eff_div_c  = sh_div;
        eff_high_c = sh_high;
      end
    end
  end

  // Shadow storage; a later load simply overwrites an untransferred one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_div   <= '0;
      sh_high  <= '0;
      sh_valid <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= xfer && (load || sh_valid);
      if (xfer) begin
        sh_valid <= 1'b0;
      end else if (load) begin
        sh_div   <= div_in;
        sh_high  <= high_in;
        sh_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/psi_pulse_gen.sv
// Programmable PSI pulse-train generator with glitch-free retuning at period boundaries.
// Ports:
//   clk, rst         clock, async active-low reset
//   enable           run level; dropping it stops the generator at the next boundary
//   load             one-cycle strobe capturing div_in (period-1) and high_in (high cycles)
//   psi              registered pulse train, high exactly while in HIGH
//   period_done      last cycle of each period (decoded from state/cnt)
//   load_ack         one-cycle pulse the cycle after new settings became active
//   busy             generator is running (not IDLE)
module psi_pulse_gen
  import psi_pkg::*;
#(
  parameter int unsigned       WIDTH    = PSI_WIDTH,
  parameter logic [WIDTH-1:0]  RST_DIV  = PSI_RST_DIV,
  parameter logic [WIDTH-1:0]  RST_HIGH = PSI_RST_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             psi,
  output logic             period_done,
  output logic             load_ack,
  output logic             busy
);

  localparam int unsigned CW = WIDTH + 1;

  psi_gen_state_t   state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cur_div;
  logic [WIDTH-1:0] cur_high;
  logic [WIDTH-1:0] eff_div_c;
  logic [WIDTH-1:0] eff_high_c;
  logic             run_c;
  logic             last_c;
  logic             xfer_c;
  logic             high_end_c;

  assign run_c       = (state != IDLE);
  assign last_c      = run_c && (cnt == cur_div);
  assign period_done = last_c;
  // Transfer only when a new period actually starts; a stopping boundary keeps the shadow pending.
  assign xfer_c      = enable && (!run_c || last_c);
  // Extra bit so cnt+1 cannot wrap into a false match.
  assign high_end_c  = ((CW'(cnt) + CW'(1)) == CW'(cur_high));

  psi_shadow_reg #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .xfer       (xfer_c),
    .div_in     (div_in),
    .high_in    (high_in),
    .cur_div    (cur_div),
    .cur_high   (cur_high),
    .eff_div_c  (eff_div_c),
    .eff_high_c (eff_high_c),
    .load_ack   (load_ack)
  );

  // Period counter, active settings and FSM; psi/busy are registered alongside state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= RST_DIV;
      cur_high <= RST_HIGH;
      psi      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (xfer_c) begin
        // New period: choose HIGH/LOW from the settings that become active now.
        cur_div  <= eff_div_c;
        cur_high <= eff_high_c;
        cnt      <= '0;
        busy     <= 1'b1;
        if (eff_high_c != '0) begin
          state <= HIGH;
          psi   <= 1'b1;
        end else begin
          state <= LOW;
          psi   <= 1'b0;
        end
      end else if (last_c) begin
        // Boundary with enable low: stop.
        state <= IDLE;
        cnt   <= '0;
        psi   <= 1'b0;
        busy  <= 1'b0;
      end else if (run_c) begin
        cnt <= cnt + WIDTH'(1);
        if ((state == HIGH) && high_end_c) begin
          state <= LOW;
          psi   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_psi_pulse_gen.sv
module tb_psi_pulse_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] div_in;
  logic [7:0] high_in;
  logic       psi;
  logic       period_done;
  logic       load_ack;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;

  psi_pulse_gen dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .div_in      (div_in),
    .high_in     (high_in),
    .psi         (psi),
    .period_done (period_done),
    .load_ack    (load_ack),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a running flag plus position inside the period; psi is "position < high".
  bit m_run;
  bit m_ack;
  bit m_sh_valid;
  int m_pos;
  int m_div;
  int m_high;
  int m_sh_div;
  int m_sh_high;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_ack = 0; m_sh_valid = 0;
      m_pos = 0; m_div = 127; m_high = 64;
      m_sh_div = 0; m_sh_high = 0;
    end else begin
      bit at_start;
      bit go;
      at_start = !m_run || (m_pos == m_div);
      go = enable && at_start;
      m_ack = 0;
      if (go) begin
        if (load) begin
          m_div = int'(div_in); m_high = int'(high_in); m_sh_valid = 0; m_ack = 1;
        end else if (m_sh_valid) begin
          m_div = m_sh_div; m_high = m_sh_high; m_sh_valid = 0; m_ack = 1;
        end
        m_run = 1;
        m_pos = 0;
      end else begin
        if (load) begin
          m_sh_div = int'(div_in); m_sh_high = int'(high_in); m_sh_valid = 1;
        end
        if (m_run) begin
          if (at_start) begin
            m_run = 0;
            m_pos = 0;
          end else begin
            m_pos = m_pos + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("psi", psi, m_run && (m_pos < m_high));
    chk("period_done", period_done, m_run && (m_pos == m_div));
    chk("busy", busy, m_run);
    chk("load_ack", load_ack, m_ack);
    if (load_ack === 1'b1) ack_count++;
  end

  task automatic do_load(input int d, input int h);
    @(negedge clk);
    load = 1'b1;
    div_in = 8'(d);
    high_in = 8'(h);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait for a boundary, then measure the following full period.
  task automatic measure(input string name, input int exp_hi, input int exp_len);
    int hi;
    int len;
    int budget;
    budget = 0;
    @(negedge clk);
    while (period_done !== 1'b1 && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 600) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_period_done required=period_done", name);
    end
    hi = 0;
    len = 0;
    do begin
      @(negedge clk);
      len++;
      if (psi === 1'b1) hi++;
    end while (period_done !== 1'b1 && len < 600);
    chk_int({name, "_high"}, hi, exp_hi);
    chk_int({name, "_len"}, len, exp_len);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    div_in = '0;
    high_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_psi", psi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pd", period_done, 1'b0);
    chk("rst_ack", load_ack, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Defaults: 64 high / 64 low.
    enable = 1'b1;
    @(negedge clk);
    chk("start_psi", psi, 1'b1);
    chk("start_busy", busy, 1'b1);
    measure("default", 64, 128);

    // Retune mid-period.
    repeat (20) @(negedge clk);
    ack_count = 0;
    do_load(9, 3);
    measure("retune", 3, 10);
    chk_int("retune_acks", ack_count, 1);

    // Two loads before a boundary: last one wins.
    ack_count = 0;
    do_load(4, 2);
    do_load(6, 1);
    measure("double_load", 1, 7);
    chk_int("double_load_acks", ack_count, 1);

    // Edge values.
    do_load(5, 0);
    measure("high0", 0, 6);
    do_load(5, 200);
    measure("high_gt_div", 6, 6);
    do_load(0, 1);
    measure("div0", 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("div0_psi", psi, 1'b1);
      chk("div0_pd", period_done, 1'b1);
    end

    // Drop enable at cnt=2 of a div=9 period.
    do_load(9, 3);
    measure("pre_drop", 3, 10);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    chk_int("drop_busy_cycles", n, 7);
    chk("drop_psi", psi, 1'b0);
    do_load(4, 2);
    repeat (3) @(negedge clk);
    chk("pending_no_ack", load_ack, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk("restart_psi", psi, 1'b1);
    measure("restart_pending", 2, 5);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 7) == 0);
      div_in = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      high_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
    end
    @(negedge clk);
    load = 1'b0;
    enable = 1'b1;

    // Asynchronous reset mid-HIGH.
    do_load(99, 50);
    measure("pre_reset", 50, 100);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    chk("pre_reset_psi", psi, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_psi", psi, 1'b0);
    chk("async_busy", busy, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_psi", psi, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_pd", period_done, 1'b0);
    chk("post_rst_ack", load_ack, 1'b0);
    enable = 1'b1;
    measure("post_rst_default", 64, 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
